z80fi_insn_collector: RTL and testbench
=======================================

# z80fi_insn_collector

Upstream stage of the Z80 formal-interface (z80fi) checkers: watches the core's retirement-side event strobes and assembles one retired-instruction packet per instruction. Output fields are opcode bytes, length, start/end IP and up to two memory reads and two memory writes. The packet drives the `z80fi_*` inputs of every `z80fi_insn_spec_*` module and the checker harness. It is purely an observer and never back-pressures the core.

## Interface
- `MAX_BYTES`, default 4: opcode-byte capacity. Fixed at 4 to match the 32-bit `z80fi_insn` field.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `insn_start`  in  1  the core begins a new instruction (first M1 fetch).
- `insn_start_pc`  in  16  PC of that first fetch.
- `fetch_valid` / `fetch_data`  in  1 / 8  an opcode or operand byte was fetched.
- `rd_valid` / `rd_addr` / `rd_data`  in  1 / 16 / 8  data memory read completed.
- `wr_valid` / `wr_addr` / `wr_data`  in  1 / 16 / 8  data memory write completed.
- `insn_done` / `insn_done_pc`  in  1 / 16  the instruction retired; PC of the next instruction.
- `z80fi_valid`  out  1  one-cycle packet strobe.
- `z80fi_insn`  out  32  opcode bytes; first byte in [7:0], then ascending byte lanes; unused bytes 0.
- `z80fi_insn_len`  out  4  number of fetched bytes (0..4).
- `z80fi_reg_ip_in` / `z80fi_reg_ip_out`  out  16 / 16  start PC / next PC.
- `z80fi_mem_rd`, `z80fi_mem_raddr`, `z80fi_mem_rdata`, `z80fi_mem_rd2`, `z80fi_mem_raddr2`, `z80fi_mem_rdata2`  out  1/16/8 ×2  first and second reads.
- `z80fi_mem_wr`, `z80fi_mem_waddr`, `z80fi_mem_wdata`, `z80fi_mem_wr2`, `z80fi_mem_waddr2`, `z80fi_mem_wdata2`  out  1/16/8 ×2  first and second writes.
- `z80fi_overflow`  out  1  packet dropped events (more than 4 bytes, 3 or more reads, or 3 or more writes).

## Operation
- States: IDLE and COLLECT.
  - IDLE → COLLECT on `insn_start`.
  - COLLECT → IDLE on `insn_done` without a simultaneous `insn_start`.
  - COLLECT → COLLECT on `insn_done` together with `insn_start`: emit the packet and begin the next one.
- On entry to COLLECT:
  - Latch `insn_start_pc` into the working IP.
  - Clear byte count, byte shift register, read/write counters and the overflow flag.
- In COLLECT:
  - Each `fetch_valid` writes `fetch_data` into lane [count] and increments the count. It saturates at 4; a fifth byte sets overflow and is discarded.
  - The first `rd_valid` fills slot 1 and the second fills slot 2. A third sets overflow. Writes follow the same rule.
- Events coinciding with `insn_done` in the same cycle belong to the retiring instruction. Events coinciding with `insn_start` belong to the new instruction.
- On `insn_done` in COLLECT, copy the working set plus `insn_done_pc` into the output registers and pulse `z80fi_valid` the next cycle.
- `insn_start` while in COLLECT without `insn_done` aborts the current packet: no `z80fi_valid`, and the working set restarts.
- `insn_done` or any data event while in IDLE is ignored.
- Packet outputs hold their values until the next emit.

## Timing
- Latency: `z80fi_valid` is high exactly the cycle after the `insn_done` edge. All packet fields are stable in that cycle.
- Back-to-back retirement (a `insn_done`+`insn_start` pair every cycle) yields a valid packet every cycle.
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - Every output is 0, including `z80fi_valid`, all flags, addresses, data, `z80fi_insn` and `z80fi_insn_len`.
- Reset mid-COLLECT discards the partial packet.
- Address arithmetic is not performed. All fields are captured verbatim; no wrap-around handling is needed.

## Structure
- Add to `z80fi.vh`:
  - `Z80FI_MAX_INSN_BYTES` (4).
  - State encodings `Z80FI_COL_IDLE` and `Z80FI_COL_COLLECT`.
- Sub-module `z80fi_mem_capture`: a 2-slot access capture with valid/addr/data inputs, clear, slot outputs and an overflow bit. It is instantiated twice, once for reads and once for writes.

## Test plan
- Start pc 0x1000, fetch DD 2A 34 12, reads (0x1234,0xCD) and (0x1235,0xAB), done pc 0x1004:
  - One valid pulse with insn=0x12342ADD, len=4, ip_in=0x1000, ip_out=0x1004.
  - rd=1, raddr=0x1234, rdata=0xCD; rd2=1, raddr2=0x1235, rdata2=0xAB; wr=0.
- NOP at pc 0x0000 (fetch 00, done pc 0x0001) with a simultaneous start at 0x0001:
  - Valid pulse with insn=0, len=1, ip_out=0x0001.
  - The next packet starts at 0x0001 with nothing carried over.
- Five fetches, or three reads:
  - Packet is still emitted with overflow=1 and len=4.
  - The first two reads are preserved.
- start, fetch 3E, start again at 0x0200 before any done:
  - No valid pulse.
  - The following packet shows ip_in=0x0200 and excludes 3E.
- reset_n low mid-COLLECT, then released, then `insn_done`:
  - All outputs are 0 during reset.
  - No valid pulse after the `insn_done`.
- `insn_done` and `rd_valid` in the same cycle:
  - The read appears in the emitted packet's rd slot.

Source files
------------

// File: rtl/z80fi_insn_collector_pkg.sv
// ---------------------------------------------------------------
// z80fi_insn_collector_pkg : shared constants and collector state type
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package z80fi_insn_collector_pkg;

  localparam int Z80FI_MAX_INSN_BYTES = 4;

  typedef enum logic [0:0] {
    Z80FI_COL_IDLE    = 1'b0,
    Z80FI_COL_COLLECT = 1'b1
  } col_state_t;

endpackage

`default_nettype wire

// File: rtl/z80fi_mem_capture.sv
// ---------------------------------------------------------------
// z80fi_mem_capture : two-slot memory access capture with overflow
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module z80fi_mem_capture (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic        slot1,
  output logic [15:0] addr1,
  output logic [7:0]  data1,
  output logic        slot2,
  output logic [15:0] addr2,
  output logic [7:0]  data2,
  output logic        overflow
);

  logic        v1, v2, ov;
  logic [15:0] a1, a2;
  logic [7:0]  d1, d2;

  // Outputs are the current slots plus this cycle's access, unless the access
  // opens a new instruction (clear), in which case it goes to the fresh set.
  always_comb begin
    slot1    = v1;
    addr1    = a1;
    data1    = d1;
    slot2    = v2;
    addr2    = a2;
    data2    = d2;
    overflow = ov;
    if (valid && !clear) begin
      if (!v1) begin
        slot1 = 1'b1;
        addr1 = addr;
        data1 = data;
      end else if (!v2) begin
        slot2 = 1'b1;
        addr2 = addr;
        data2 = data;
      end else begin
        overflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;  a1 <= '0;  d1 <= '0;
      v2 <= 1'b0;  a2 <= '0;  d2 <= '0;
      ov <= 1'b0;
    end else if (clear) begin
      v1 <= valid;
      a1 <= valid ? addr : 16'h0000;
      d1 <= valid ? data : 8'h00;
      v2 <= 1'b0;  a2 <= '0;  d2 <= '0;
      ov <= 1'b0;
    end else begin
      v1 <= slot1;  a1 <= addr1;  d1 <= data1;
      v2 <= slot2;  a2 <= addr2;  d2 <= data2;
      ov <= overflow;
    end
  end

endmodule

`default_nettype wire

// File: rtl/z80fi_insn_collector.sv
// ---------------------------------------------------------------
// z80fi_insn_collector : assembles one retired-instruction packet per insn
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module z80fi_insn_collector
  import z80fi_insn_collector_pkg::*;
#(
  parameter int MAX_BYTES = Z80FI_MAX_INSN_BYTES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        insn_start,
  input  logic [15:0] insn_start_pc,
  input  logic        fetch_valid,
  input  logic [7:0]  fetch_data,
  input  logic        rd_valid,
  input  logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        insn_done,
  input  logic [15:0] insn_done_pc,
  output logic        z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [3:0]  z80fi_insn_len,
  output logic [15:0] z80fi_reg_ip_in,
  output logic [15:0] z80fi_reg_ip_out,
  output logic        z80fi_mem_rd,
  output logic [15:0] z80fi_mem_raddr,
  output logic [7:0]  z80fi_mem_rdata,
  output logic        z80fi_mem_rd2,
  output logic [15:0] z80fi_mem_raddr2,
  output logic [7:0]  z80fi_mem_rdata2,
  output logic        z80fi_mem_wr,
  output logic [15:0] z80fi_mem_waddr,
  output logic [7:0]  z80fi_mem_wdata,
  output logic        z80fi_mem_wr2,
  output logic [15:0] z80fi_mem_waddr2,
  output logic [7:0]  z80fi_mem_wdata2,
  output logic        z80fi_overflow
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_BYTES);

  col_state_t state, state_nxt;
  logic       emit, capturing;

  logic [15:0]            ip_work;
  logic [MAX_BYTES*8-1:0] bytes, bytes_m;
  logic [2:0]             count, count_m;
  logic                   byte_ovf, byte_ovf_m;

  logic        rd1_m, rd2_m, rd_ovf_m, wr1_m, wr2_m, wr_ovf_m;
  logic [15:0] raddr1_m, raddr2_m, waddr1_m, waddr2_m;
  logic [7:0]  rdata1_m, rdata2_m, wdata1_m, wdata2_m;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= Z80FI_COL_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      Z80FI_COL_IDLE: begin
        if (insn_start) state_nxt = Z80FI_COL_COLLECT;
      end
      Z80FI_COL_COLLECT: begin
        emit = insn_done;
        if (insn_done && !insn_start) state_nxt = Z80FI_COL_IDLE;
      end
      default: state_nxt = Z80FI_COL_IDLE;
    endcase
  end

  assign capturing = (state == Z80FI_COL_COLLECT) || insn_start;

  // Retiring view of the opcode bytes: a fetch alongside insn_start is the
  // new instruction's first byte and is excluded here.
  always_comb begin
    bytes_m    = bytes;
    count_m    = count;
    byte_ovf_m = byte_ovf;
    if (fetch_valid && !insn_start) begin
      if (count < MAX_CNT) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (count == 3'(i)) bytes_m[i*8 +: 8] = fetch_data;
        end
        count_m = count + 3'd1;
      end else begin
        byte_ovf_m = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ip_work  <= '0;
      bytes    <= '0;
      count    <= '0;
      byte_ovf <= 1'b0;
    end else if (insn_start) begin
      ip_work  <= insn_start_pc;
      bytes    <= fetch_valid ? (MAX_BYTES*8)'(fetch_data) : '0;
      count    <= fetch_valid ? 3'd1 : 3'd0;
      byte_ovf <= 1'b0;
    end else if (state == Z80FI_COL_COLLECT) begin
      bytes    <= bytes_m;
      count    <= count_m;
      byte_ovf <= byte_ovf_m;
    end
  end

  z80fi_mem_capture u_rd_cap (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (insn_start),
    .valid    (rd_valid && capturing),
    .addr     (rd_addr),
    .data     (rd_data),
    .slot1    (rd1_m),
    .addr1    (raddr1_m),
    .data1    (rdata1_m),
    .slot2    (rd2_m),
    .addr2    (raddr2_m),
    .data2    (rdata2_m),
    .overflow (rd_ovf_m)
  );

  z80fi_mem_capture u_wr_cap (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (insn_start),
    .valid    (wr_valid && capturing),
    .addr     (wr_addr),
    .data     (wr_data),
    .slot1    (wr1_m),
    .addr1    (waddr1_m),
    .data1    (wdata1_m),
    .slot2    (wr2_m),
    .addr2    (waddr2_m),
    .data2    (wdata2_m),
    .overflow (wr_ovf_m)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z80fi_valid      <= 1'b0;
      z80fi_insn       <= '0;
      z80fi_insn_len   <= '0;
      z80fi_reg_ip_in  <= '0;
      z80fi_reg_ip_out <= '0;
      z80fi_mem_rd     <= 1'b0;
      z80fi_mem_raddr  <= '0;
      z80fi_mem_rdata  <= '0;
      z80fi_mem_rd2    <= 1'b0;
      z80fi_mem_raddr2 <= '0;
      z80fi_mem_rdata2 <= '0;
      z80fi_mem_wr     <= 1'b0;
      z80fi_mem_waddr  <= '0;
      z80fi_mem_wdata  <= '0;
      z80fi_mem_wr2    <= 1'b0;
      z80fi_mem_waddr2 <= '0;
      z80fi_mem_wdata2 <= '0;
      z80fi_overflow   <= 1'b0;
    end else begin
      z80fi_valid <= emit;
      if (emit) begin
        z80fi_insn       <= 32'(bytes_m);
        z80fi_insn_len   <= {1'b0, count_m};
        z80fi_reg_ip_in  <= ip_work;
        z80fi_reg_ip_out <= insn_done_pc;
        z80fi_mem_rd     <= rd1_m;
        z80fi_mem_raddr  <= raddr1_m;
        z80fi_mem_rdata  <= rdata1_m;
        z80fi_mem_rd2    <= rd2_m;
        z80fi_mem_raddr2 <= raddr2_m;
        z80fi_mem_rdata2 <= rdata2_m;
        z80fi_mem_wr     <= wr1_m;
        z80fi_mem_waddr  <= waddr1_m;
        z80fi_mem_wdata  <= wdata1_m;
        z80fi_mem_wr2    <= wr2_m;
        z80fi_mem_waddr2 <= waddr2_m;
        z80fi_mem_wdata2 <= wdata2_m;
        z80fi_overflow   <= byte_ovf_m | rd_ovf_m | wr_ovf_m;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_z80fi_insn_collector.sv
// ---------------------------------------------------------------
// tb_z80fi_insn_collector : scoreboard bench for the packet collector
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_z80fi_insn_collector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        insn_start, fetch_valid, rd_valid, wr_valid, insn_done;
  logic [15:0] insn_start_pc, rd_addr, wr_addr, insn_done_pc;
  logic [7:0]  fetch_data, rd_data, wr_data;

  logic        z80fi_valid, z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2, z80fi_overflow;
  logic [31:0] z80fi_insn;
  logic [3:0]  z80fi_insn_len;
  logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out;
  logic [15:0] z80fi_mem_raddr, z80fi_mem_raddr2, z80fi_mem_waddr, z80fi_mem_waddr2;
  logic [7:0]  z80fi_mem_rdata, z80fi_mem_rdata2, z80fi_mem_wdata, z80fi_mem_wdata2;

  always #5 clk = ~clk;

  z80fi_insn_collector dut (
    .clk(clk), .reset_n(reset_n),
    .insn_start(insn_start), .insn_start_pc(insn_start_pc),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .insn_done(insn_done), .insn_done_pc(insn_done_pc),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_ip_out(z80fi_reg_ip_out),
    .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata),
    .z80fi_mem_rd2(z80fi_mem_rd2), .z80fi_mem_raddr2(z80fi_mem_raddr2), .z80fi_mem_rdata2(z80fi_mem_rdata2),
    .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
    .z80fi_mem_wr2(z80fi_mem_wr2), .z80fi_mem_waddr2(z80fi_mem_waddr2), .z80fi_mem_wdata2(z80fi_mem_wdata2),
    .z80fi_overflow(z80fi_overflow)
  );

  typedef struct packed {
    logic [31:0] insn;
    logic [3:0]  len;
    logic [15:0] ip_in, ip_out;
    logic        rd;  logic [15:0] raddr;  logic [7:0] rdata;
    logic        rd2; logic [15:0] raddr2; logic [7:0] rdata2;
    logic        wr;  logic [15:0] waddr;  logic [7:0] wdata;
    logic        wr2; logic [15:0] waddr2; logic [7:0] wdata2;
    logic        ovf;
  } pkt_t;

  pkt_t exp_q[$];
  int   checks = 0, passes = 0, pushed = 0, seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  function automatic pkt_t pk(input logic [31:0] insn, input logic [3:0] len,
                              input logic [15:0] ip_in, input logic [15:0] ip_out);
    pkt_t p;
    p = '0;
    p.insn = insn; p.len = len; p.ip_in = ip_in; p.ip_out = ip_out;
    return p;
  endfunction

  task automatic expect_pkt(input pkt_t p);
    exp_q.push_back(p);
    pushed++;
  endtask

  always @(negedge clk) begin
    if (reset_n && z80fi_valid) begin
      seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(z80fi_valid), 32'd0);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        chk("insn",   z80fi_insn, e.insn);
        chk("len",    32'(z80fi_insn_len), 32'(e.len));
        chk("ip_in",  32'(z80fi_reg_ip_in), 32'(e.ip_in));
        chk("ip_out", 32'(z80fi_reg_ip_out), 32'(e.ip_out));
        chk("rd",     32'({z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata}), 32'({e.rd, e.raddr, e.rdata}));
        chk("rd2",    32'({z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2}), 32'({e.rd2, e.raddr2, e.rdata2}));
        chk("wr",     32'({z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata}), 32'({e.wr, e.waddr, e.wdata}));
        chk("wr2",    32'({z80fi_mem_wr2, z80fi_mem_waddr2, z80fi_mem_wdata2}), 32'({e.wr2, e.waddr2, e.wdata2}));
        chk("overflow", 32'(z80fi_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic clear_in();
    insn_start = 0; insn_start_pc = '0; fetch_valid = 0; fetch_data = '0;
    rd_valid = 0; rd_addr = '0; rd_data = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    insn_done = 0; insn_done_pc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic start(input logic [15:0] pc);
    insn_start = 1; insn_start_pc = pc;
  endtask
  task automatic fetch(input logic [7:0] b);
    fetch_valid = 1; fetch_data = b;
  endtask
  task automatic rd(input logic [15:0] a, input logic [7:0] d);
    rd_valid = 1; rd_addr = a; rd_data = d;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
  endtask
  task automatic done(input logic [15:0] pc);
    insn_done = 1; insn_done_pc = pc;
  endtask

  function automatic logic any_output();
    return |{z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_reg_ip_in, z80fi_reg_ip_out,
             z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata, z80fi_mem_rd2, z80fi_mem_raddr2,
             z80fi_mem_rdata2, z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata, z80fi_mem_wr2,
             z80fi_mem_waddr2, z80fi_mem_wdata2, z80fi_overflow};
  endfunction

  initial begin
    pkt_t p;
    reset_n = 0;
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(z80fi_valid), 32'd0);
    chk("reset_all_outputs", 32'(any_output()), 32'd0);
    reset_n = 1;
    tick();

    // LD HL,(1234h) style: four bytes, two reads
    start(16'h1000); fetch(8'hDD); tick();
    fetch(8'h2A); tick();
    fetch(8'h34); rd(16'h1234, 8'hCD); tick();
    fetch(8'h12); rd(16'h1235, 8'hAB); tick();
    p = pk(32'h12342ADD, 4'd4, 16'h1000, 16'h1004);
    p.rd = 1; p.raddr = 16'h1234; p.rdata = 8'hCD;
    p.rd2 = 1; p.raddr2 = 16'h1235; p.rdata2 = 8'hAB;
    expect_pkt(p);
    done(16'h1004); tick();
    tick();

    // NOP retiring with the next start in the same cycle
    start(16'h0000); fetch(8'h00); tick();
    expect_pkt(pk(32'h0, 4'd1, 16'h0000, 16'h0001));
    done(16'h0001); start(16'h0001); tick();
    fetch(8'h3C); wr(16'h8000, 8'h55); tick();
    p = pk(32'h3C, 4'd1, 16'h0001, 16'h0002);
    p.wr = 1; p.waddr = 16'h8000; p.wdata = 8'h55;
    expect_pkt(p);
    done(16'h0002); tick();
    tick();

    // Fifth fetch byte overflows and is discarded
    start(16'h2000); fetch(8'h01); tick();
    for (int b = 2; b <= 5; b++) begin
      fetch(8'(b)); tick();
    end
    p = pk(32'h04030201, 4'd4, 16'h2000, 16'h2005);
    p.ovf = 1;
    expect_pkt(p);
    done(16'h2005); tick();
    tick();

    // Third read overflows; both writes kept
    start(16'h3000); fetch(8'hED); tick();
    rd(16'h0010, 8'h11); tick();
    rd(16'h0020, 8'h22); wr(16'h0040, 8'h44); tick();
    rd(16'h0030, 8'h33); wr(16'h0050, 8'h55); tick();
    p = pk(32'hED, 4'd1, 16'h3000, 16'h3001);
    p.rd = 1; p.raddr = 16'h0010; p.rdata = 8'h11;
    p.rd2 = 1; p.raddr2 = 16'h0020; p.rdata2 = 8'h22;
    p.wr = 1; p.waddr = 16'h0040; p.wdata = 8'h44;
    p.wr2 = 1; p.waddr2 = 16'h0050; p.wdata2 = 8'h55;
    p.ovf = 1;
    expect_pkt(p);
    done(16'h3001); tick();
    tick();

    // Restart before retirement aborts the partial packet
    start(16'h0100); fetch(8'h3E); tick();
    start(16'h0200); fetch(8'h06); tick();
    fetch(8'h07); tick();
    expect_pkt(pk(32'h0706, 4'd2, 16'h0200, 16'h0202));
    done(16'h0202); tick();
    tick();

    // Read in the retirement cycle belongs to the retiring packet
    start(16'h4000); fetch(8'h7E); tick();
    p = pk(32'h7E, 4'd1, 16'h4000, 16'h4001);
    p.rd = 1; p.raddr = 16'h5555; p.rdata = 8'h99;
    expect_pkt(p);
    done(16'h4001); rd(16'h5555, 8'h99); tick();
    tick();

    // Back-to-back retirement every cycle
    start(16'h0010); fetch(8'h00); tick();
    expect_pkt(pk(32'h00, 4'd1, 16'h0010, 16'h0011));
    done(16'h0011); start(16'h0011); fetch(8'h01); tick();
    expect_pkt(pk(32'h01, 4'd1, 16'h0011, 16'h0012));
    done(16'h0012); start(16'h0012); fetch(8'h02); tick();
    expect_pkt(pk(32'h02, 4'd1, 16'h0012, 16'h0013));
    done(16'h0013); tick();
    tick();

    // Reset mid-collect drops the partial packet
    start(16'h6000); fetch(8'hAA); tick();
    fetch(8'hBB);
    #2;
    reset_n = 0;
    #2;
    chk("midreset_all_outputs", 32'(any_output()), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1;
    clear_in();
    tick();
    done(16'h6001); tick();
    rd(16'h7000, 8'h01); tick();
    repeat (3) tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("packets_seen", 32'(seen), 32'(pushed));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
